// File: rtl/bcd_frequency_entry.sv
// Seven-digit BCD frequency entry with digit cursor and decimal carry/borrow ripple.
// One digit is rippled per cycle; overflow saturates at 9999999 and underflow clamps at 0.
module bcd_frequency_entry #(
    parameter logic [27:0] RESET_BCD  = 28'h0001000,
    parameter logic [2:0]  CURSOR_RST = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_enter,
    output logic [3:0] d_1,
    output logic [3:0] d_2,
    output logic [3:0] d_3,
    output logic [3:0] d_4,
    output logic [3:0] d_5,
    output logic [3:0] d_6,
    output logic [3:0] d_7,
    output logic [2:0] cursor,
    output logic       busy,
    output logic       commit
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CARRY  = 2'd1,
        BORROW = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] dig_q [7];
    logic [3:0] dig_d [7];
    logic [2:0] cursor_q, cursor_d;
    logic [2:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
    logic       commit_q, commit_d;

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        cursor_d = cursor_q;
        ptr_d    = ptr_q;
        commit_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_up) begin
                    if (dig_q[cursor_q] < 4'd9) begin
                        dig_d[cursor_q] = dig_q[cursor_q] + 4'd1;
                    end else begin
                        dig_d[cursor_q] = 4'd0;
                        ptr_d           = cursor_q + 3'd1;
                        state_d         = CARRY;
                    end
                end else if (btn_down) begin
                    if (dig_q[cursor_q] > 4'd0) begin
                        dig_d[cursor_q] = dig_q[cursor_q] - 4'd1;
                    end else begin
                        dig_d[cursor_q] = 4'd9;
                        ptr_d           = cursor_q + 3'd1;
                        state_d         = BORROW;
                    end
                end else if (btn_left) begin
                    cursor_d = (cursor_q == 3'd6) ? 3'd0 : cursor_q + 3'd1;
                end else if (btn_right) begin
                    cursor_d = (cursor_q == 3'd0) ? 3'd6 : cursor_q - 3'd1;
                end else if (btn_enter) begin
                    commit_d = 1'b1;
                end
            end
            CARRY: begin
                // Carry out of the top digit saturates the whole word
                if (ptr_q == 3'd7) begin
                    for (int k = 0; k < 7; k++) dig_d[k] = 4'd9;
                    state_d = IDLE;
                end else if (dig_q[ptr_q] < 4'd9) begin
                    dig_d[ptr_q] = dig_q[ptr_q] + 4'd1;
                    state_d      = IDLE;
                end else begin
                    dig_d[ptr_q] = 4'd0;
                    ptr_d        = ptr_q + 3'd1;
                end
            end
            BORROW: begin
                if (ptr_q == 3'd7) begin
                    for (int k = 0; k < 7; k++) dig_d[k] = 4'd0;
                    state_d = IDLE;
                end else if (dig_q[ptr_q] > 4'd0) begin
                    dig_d[ptr_q] = dig_q[ptr_q] - 4'd1;
                    state_d      = IDLE;
                end else begin
                    dig_d[ptr_q] = 4'd9;
                    ptr_d        = ptr_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cursor_q <= CURSOR_RST;
            ptr_q    <= 3'd0;
            busy_q   <= 1'b0;
            commit_q <= 1'b0;
            for (int k = 0; k < 7; k++) dig_q[k] <= RESET_BCD[4*k +: 4];
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            commit_q <= commit_d;
            dig_q    <= dig_d;
        end
    end

    assign d_1    = dig_q[0];
    assign d_2    = dig_q[1];
    assign d_3    = dig_q[2];
    assign d_4    = dig_q[3];
    assign d_5    = dig_q[4];
    assign d_6    = dig_q[5];
    assign d_7    = dig_q[6];
    assign cursor = cursor_q;
    assign busy   = busy_q;
    assign commit = commit_q;

endmodule
